// File: rtl/ram_stream_reader_if.sv
// Stream side of the RAM reader: valid/ready beat with data and end-of-transfer marker.
interface ram_stream_reader_if #(parameter int WIDTH = 32);
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Reads a block of words from a 1-cycle-latency RAM and streams them out
// through a 2-entry skid FIFO, with abort and zero/full-length transfers.
//   state | meaning
//   IDLE  | waiting for start; no reads issued
//   RUN   | issuing reads and streaming returned words
//   DRAIN | all reads issued; streaming the remaining words
module ram_stream_reader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DEPTH-1:0]     base,
  input  logic [DEPTH:0]       count,
  input  logic                 abort,
  output logic [DEPTH-1:0]     raddress,
  output logic                 ram_re,
  input  logic [WIDTH-1:0]     rdata,
  ram_stream_reader_if.master  m_if,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH:0]   issue_left_q, issue_left_d;
  logic [DEPTH:0]   beat_left_q, beat_left_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] fifo0_q, fifo0_d;
  logic [WIDTH-1:0] fifo1_q, fifo1_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             done_q, done_d;

  logic             valid;
  logic             pop;
  logic [2:0]       occ_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      inflight_q   <= 1'b0;
      fifo0_q      <= '0;
      fifo1_q      <= '0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      occ_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      inflight_q   <= inflight_d;
      fifo0_q      <= fifo0_d;
      fifo1_q      <= fifo1_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      occ_q        <= occ_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    valid   = (occ_q != 2'd0);
    pop     = valid && m_if.m_ready;
    // Occupancy the FIFO would have next cycle; a new issue is allowed only if it still fits.
    occ_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    ram_re  = (state_q == RUN) && (issue_left_q != '0) && (occ_sum < 3'd2);

    raddress      = rd_ptr_q;
    m_if.m_valid  = valid;
    m_if.m_data   = head_q ? fifo1_q : fifo0_q;
    m_if.m_last   = valid && (beat_left_q == (DEPTH+1)'(1));
    busy          = (state_q != IDLE);
    done          = done_q;

    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    inflight_d   = 1'b0;
    fifo0_d      = fifo0_q;
    fifo1_d      = fifo1_q;
    head_d       = head_q;
    tail_d       = tail_q;
    occ_d        = occ_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rd_ptr_d     = base;
          issue_left_d = count;
          beat_left_d  = count;
          if (count == '0) done_d = 1'b1;
          else             state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
          occ_d   = '0;
          head_d  = 1'b0;
          tail_d  = 1'b0;
        end else begin
          if (ram_re) begin
            rd_ptr_d     = rd_ptr_q + DEPTH'(1);
            issue_left_d = issue_left_q - (DEPTH+1)'(1);
          end
          inflight_d = ram_re;
          if (inflight_q) begin
            if (tail_q) fifo1_d = rdata;
            else        fifo0_d = rdata;
            tail_d = ~tail_q;
          end
          if (pop) begin
            head_d      = ~head_q;
            beat_left_d = beat_left_q - (DEPTH+1)'(1);
          end
          occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop};
          if (state_q == RUN && issue_left_d == '0) state_d = DRAIN;
          if (pop && m_if.m_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 16-word RAM model (RAM[i] = i+100).
module tb_ram_stream_reader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DEPTH-1:0] base = '0;
  logic [DEPTH:0]   count = '0;
  logic [DEPTH-1:0] raddress;
  logic             ram_re;
  logic [WIDTH-1:0] rdata = '0;
  logic             busy;
  logic             done;

  ram_stream_reader_if #(.WIDTH(WIDTH)) s_if ();

  ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base     (base),
    .count    (count),
    .abort    (abort),
    .raddress (raddress),
    .ram_re   (ram_re),
    .rdata    (rdata),
    .m_if     (s_if),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] ram [16];
  always @(posedge clk) if (ram_re) rdata <= ram[raddress];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] beats[$];
  bit               lasts[$];
  int               addrs[$];
  int               done_cnt = 0;
  bit               stall_q = 1'b0;
  logic [WIDTH-1:0] stall_data;
  logic             stall_last;
  bit               pat [8] = '{1, 0, 0, 1, 1, 0, 1, 0};

  always @(negedge clk) begin
    if (reset) begin
      if (stall_q) begin
        chk("stall_valid", 32'(s_if.m_valid), 32'd1);
        chk("stall_data", 32'(s_if.m_data), 32'(stall_data));
        chk("stall_last", 32'(s_if.m_last), 32'(stall_last));
      end
      stall_q    = s_if.m_valid && !s_if.m_ready;
      stall_data = s_if.m_data;
      stall_last = s_if.m_last;
      if (s_if.m_valid && s_if.m_ready) begin
        beats.push_back(s_if.m_data);
        lasts.push_back(s_if.m_last);
      end
      if (ram_re) addrs.push_back(int'(raddress));
      if (done) done_cnt++;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic clear_log();
    beats.delete();
    lasts.delete();
    addrs.delete();
    done_cnt = 0;
  endtask

  task automatic kick(input int b, input int c);
    @(posedge clk); #1;
    base  = DEPTH'(b);
    count = (DEPTH+1)'(c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic xfer(input string tag, input int b, input int c, input bit bp);
    clear_log();
    s_if.m_ready = 1'b1;
    kick(b, c);
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      if (bp) s_if.m_ready = pat[cyc % 8];
      @(posedge clk); #1;
    end
    s_if.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_beats"}, 32'(beats.size()), 32'(c));
    chk({tag, "_reads"}, 32'(addrs.size()), 32'(c));
    for (int i = 0; i < beats.size(); i++) begin
      chk({tag, "_data"}, 32'(beats[i]), 32'(((b + i) % 16) + 100));
      chk({tag, "_last"}, 32'(lasts[i]), 32'(i == c - 1));
    end
    for (int i = 0; i < addrs.size(); i++)
      chk({tag, "_addr"}, 32'(addrs[i]), 32'((b + i) % 16));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = WIDTH'(i + 100);
    s_if.m_ready = 1'b1;

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(s_if.m_valid), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_raddress", 32'(raddress), 32'd0);
    chk("rst_m_data", 32'(s_if.m_data), 32'd0);
    @(negedge clk); #2;
    reset = 1'b1;

    // basic read: cycle-by-cycle latency and data
    clear_log();
    kick(5, 4);
    @(negedge clk);
    chk("c1_ram_re", 32'(ram_re), 32'd1);
    chk("c1_raddress", 32'(raddress), 32'd5);
    chk("c1_valid", 32'(s_if.m_valid), 32'd0);
    chk("c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("c2_valid", 32'(s_if.m_valid), 32'd0);
    chk("c2_raddress", 32'(raddress), 32'd6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("basic_valid", 32'(s_if.m_valid), 32'd1);
      chk("basic_data", 32'(s_if.m_data), 32'(105 + i));
      chk("basic_last", 32'(s_if.m_last), 32'(i == 3));
      chk("basic_done_low", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_valid_end", 32'(s_if.m_valid), 32'd0);
    @(negedge clk);
    chk("basic_done_pulse", 32'(done), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt), 32'd1);

    xfer("wrap", 14, 4, 1'b0);
    xfer("bp", 11, 6, 1'b1);
    xfer("full", 3, 16, 1'b0);
    xfer("full_bp", 0, 16, 1'b1);

    // zero count
    clear_log();
    kick(7, 0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_ram_re", 32'(ram_re), 32'd0);
    repeat (4) @(negedge clk);
    chk("zero_done_cnt", 32'(done_cnt), 32'd1);
    chk("zero_beats", 32'(beats.size()), 32'd0);
    chk("zero_reads", 32'(addrs.size()), 32'd0);

    // abort during the 2nd beat
    clear_log();
    kick(0, 8);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_beat2_data", 32'(s_if.m_data), 32'd101);
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 32'(s_if.m_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_ram_re", 32'(ram_re), 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_done_cnt", 32'(done_cnt), 32'd1);
    chk("abort_beats", 32'(beats.size()), 32'd2);
    @(posedge clk); #1 abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_done", 32'(done), 32'd0);
    abort = 1'b0;
    xfer("post_abort", 2, 3, 1'b0);

    // abort and start together in IDLE: start wins
    clear_log();
    @(posedge clk); #1;
    base = 4'd6; count = 5'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_prio_busy", 32'(busy), 32'd1);
    repeat (6) @(negedge clk);
    chk("start_prio_beats", 32'(beats.size()), 32'd2);
    chk("start_prio_done_cnt", 32'(done_cnt), 32'd1);

    // reset during beat 3
    clear_log();
    kick(4, 8);
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mrst_valid", 32'(s_if.m_valid), 32'd0);
    chk("mrst_last", 32'(s_if.m_last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ram_re", 32'(ram_re), 32'd0);
    chk("mrst_raddress", 32'(raddress), 32'd0);
    chk("mrst_m_data", 32'(s_if.m_data), 32'd0);
    @(negedge clk); #2 reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_no_done", 32'(done_cnt), 32'd0);
    xfer("post_rst", 9, 5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
